// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART transmit scheduler and the rest of the UART
// subsystem (the RX side uses CLKS_PER_BIT_9600 too).
//   UART_DATA_BITS    : payload bits per 8N1 frame
//   CLKS_PER_BIT_9600 : system clocks per bit at 9600 baud
//   ST_*              : transmit FSM state encoding
//   idx_w()           : index width for n items, never less than 1
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int CLKS_PER_BIT_9600 = 1250;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin select with a lock override.
//   valid        : per-requester request
//   ptr          : last round-robin winner; search starts at ptr+1
//   lock_active  : a requester currently holds the lock
//   lock_id      : lock holder index
//   gnt_onehot   : one-hot winner (all zero when nobody is valid)
//   gnt_idx      : winner index
//   gnt_any      : some requester won
//   gnt_via_lock : the win came from the lock, not from round-robin
// -----------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               lock_active,
    input  logic [IDX_W-1:0]   lock_id,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any,
    output logic               gnt_via_lock
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_onehot   = '0;
        gnt_idx      = '0;
        gnt_any      = 1'b0;
        gnt_via_lock = 1'b0;
        cand         = '0;
        if (lock_active && valid[lock_id]) begin
            gnt_any      = 1'b1;
            gnt_via_lock = 1'b1;
            gnt_idx      = lock_id;
        end else begin
            // Walk ptr+1, ptr+2, ... wrapping; ptr itself is checked last.
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
                if (!gnt_any && valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (gnt_any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART TX line between NUM_REQ byte producers. A round-robin
// arbiter (with optional lock for multi-byte messages) picks one requester per
// frame; the FSM sends 8N1 frames at CLKS_PER_BIT clocks per bit.
//   i_CLK, i_RST_N : clock, asynchronous active-low reset
//   i_REQ_VALID    : per-requester byte valid (hold with data until ready)
//   i_REQ_DATA     : packed bytes, requester k at [8k+7:8k]
//   i_REQ_LOCK     : keep ownership after the current frame
//   o_REQ_READY    : one-hot accept strobe, only in IDLE
//   o_GRANT_ID     : current or last owner
//   o_BUSY         : frame in progress
//   o_UART_TXD     : serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter int DATA_W       = UART_DATA_BITS
) (
    input  logic                        i_CLK,
    input  logic                        i_RST_N,
    input  logic [NUM_REQ-1:0]          i_REQ_VALID,
    input  logic [NUM_REQ*DATA_W-1:0]   i_REQ_DATA,
    input  logic [NUM_REQ-1:0]          i_REQ_LOCK,
    output logic [NUM_REQ-1:0]          o_REQ_READY,
    output logic [idx_w(NUM_REQ)-1:0]   o_GRANT_ID,
    output logic                        o_BUSY,
    output logic                        o_UART_TXD
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = idx_w(CLKS_PER_BIT);
    localparam int BIT_W = idx_w(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    if (DATA_W != UART_DATA_BITS) begin : g_bad_data_w
        $error("uart_tx_scheduler: DATA_W must be 8");
    end

    logic [1:0]         state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic               txd;
    logic [IDX_W-1:0]   grant_id;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_id;
    logic               lock_active;
    logic               via_lock_q;
    logic               run_en;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               arb_via_lock;
    logic               accept;
    logic               baud_done;
    logic [DATA_W-1:0]  sel_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .valid        (i_REQ_VALID),
        .ptr          (rr_ptr),
        .lock_active  (lock_active),
        .lock_id      (lock_id),
        .gnt_onehot   (arb_oh),
        .gnt_idx      (arb_idx),
        .gnt_any      (arb_any),
        .gnt_via_lock (arb_via_lock)
    );

    // run_en holds off accepts until the first clock after reset release,
    // so ready stays low for the whole time reset is asserted.
    assign accept    = run_en && (state == ST_IDLE) && arb_any;
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                sel_byte = i_REQ_DATA[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            txd         <= 1'b1;
            grant_id    <= '0;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);   // requester 0 searched first
            lock_id     <= '0;
            lock_active <= 1'b0;
            via_lock_q  <= 1'b0;
            run_en      <= 1'b0;
        end else begin
            run_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // A lock holder that stops requesting gives up the lock.
                    if (lock_active && !i_REQ_VALID[lock_id]) begin
                        lock_active <= 1'b0;
                    end
                    if (accept) begin
                        state      <= ST_START;
                        baud_cnt   <= '0;
                        txd        <= 1'b0;
                        shreg      <= sel_byte;
                        grant_id   <= arb_idx;
                        via_lock_q <= arb_via_lock;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shreg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {1'b0, shreg[DATA_W-1:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt    <= '0;
                        state       <= ST_IDLE;
                        lock_active <= i_REQ_LOCK[grant_id];
                        lock_id     <= grant_id;
                        // Locked frames do not move the round-robin pointer.
                        if (!via_lock_q) begin
                            rr_ptr <= grant_id;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_REQ_READY = accept ? arb_oh : '0;
    assign o_GRANT_ID  = grant_id;
    assign o_BUSY      = (state != ST_IDLE);
    assign o_UART_TXD  = txd;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 2;
    localparam int CPB     = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_lock;
    logic [1:0]  req_ready;
    logic        grant_id;
    logic        busy;
    logic        txd;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
        .i_REQ_VALID (req_valid),
        .i_REQ_DATA  (req_data),
        .i_REQ_LOCK  (req_lock),
        .o_REQ_READY (req_ready),
        .o_GRANT_ID  (grant_id),
        .o_BUSY      (busy),
        .o_UART_TXD  (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects an accept of byte d from requester id in the current IDLE cycle,
    // then a full 40-cycle 8N1 frame, returning in the first IDLE cycle after.
    task automatic expect_frame(input logic [7:0] d, input int id, input string tag);
        logic [9:0] exp_bits;
        logic [9:0] got_bits;
        int bad, busy_n, rdy_n;
        exp_bits = {1'b1, d, 1'b0};
        got_bits = '0;
        bad = 0; busy_n = 0; rdy_n = 0;
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(1 << id));
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        tick();
        check({tag, ".grant"}, 32'(grant_id), 32'(id));
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k % CPB == 1) got_bits[k / CPB] = txd;
            if (txd !== exp_bits[k / CPB]) bad++;
            if (busy === 1'b1) busy_n++;
            if (req_ready !== 2'b00) rdy_n++;
            tick();
        end
        check({tag, ".bits"}, 32'(got_bits), 32'(exp_bits));
        check({tag, ".bit_cycles_bad"}, 32'(bad), 32'd0);
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'(10 * CPB));
        check({tag, ".ready_in_frame"}, 32'(rdy_n), 32'd0);
        check({tag, ".end_busy"}, 32'(busy), 32'd0);
        check({tag, ".end_txd"}, 32'(txd), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_n;
        int waited;
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_data = 16'h0000;
        req_lock = 2'b00;

        // Reset state
        repeat (3) tick();
        check("rst.txd", 32'(txd), 32'd1);
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.grant", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte from req0
        req_valid = 2'b01; req_data = 16'h0061;
        expect_frame(8'h61, 0, "single");
        req_valid = 2'b00;
        repeat (3) tick();
        check("single.after_busy", 32'(busy), 32'd0);
        check("single.after_ready", 32'(req_ready), 32'd0);

        // Contention from reset release, three back-to-back rounds
        rst_n = 1'b0;
        tick();
        req_valid = 2'b11; req_data = {8'h3C, 8'hA5};
        rst_n = 1'b1;
        tick();
        expect_frame(8'hA5, 0, "cont1");
        expect_frame(8'h3C, 1, "cont2");
        expect_frame(8'hA5, 0, "cont3");
        req_valid = 2'b00;

        // Lock: req1 keeps the line for three bytes while req0 waits
        req_valid = 2'b11; req_data = {8'h10, 8'h77}; req_lock = 2'b10;
        expect_frame(8'h10, 1, "lock1");
        req_data[15:8] = 8'h11;
        expect_frame(8'h11, 1, "lock2");
        req_data[15:8] = 8'h12; req_lock = 2'b00;
        expect_frame(8'h12, 1, "lock3");
        req_data[15:8] = 8'h13;
        expect_frame(8'h77, 0, "lock_after");
        req_valid = 2'b00;

        // Lock released because the owner is not valid in IDLE
        req_valid = 2'b10; req_data = {8'h20, 8'h00}; req_lock = 2'b10;
        expect_frame(8'h20, 1, "rel1");
        req_valid = 2'b01; req_data = {8'h00, 8'h30}; req_lock = 2'b00;
        expect_frame(8'h30, 0, "rel2");
        req_valid = 2'b00;

        // Reset in the middle of a frame
        req_valid = 2'b10; req_data = {8'hC3, 8'h00};
        #1;
        check("midrst.ready_pre", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        repeat (15) tick();
        check("midrst.busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.txd", 32'(txd), 32'd1);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.ready", 32'(req_ready), 32'd0);
        check("midrst.grant", 32'(grant_id), 32'd0);
        tick();
        req_valid = 2'b01; req_data = {8'h00, 8'h55};
        #1;
        check("midrst.ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_frame(8'h55, 0, "post_rst");
        req_valid = 2'b00;

        // Valid raised during a frame must wait for IDLE, then be taken once
        req_valid = 2'b10; req_data = {8'h81, 8'h00};
        #1;
        check("hold.first_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        repeat (5) tick();
        req_valid = 2'b01; req_data = {8'h00, 8'hE7};
        rdy_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready !== 2'b00) rdy_n++;
            tick();
        end
        waited = 0;
        while (busy === 1'b1 && waited < 40) begin
            if (req_ready !== 2'b00) rdy_n++;
            tick();
            waited++;
        end
        check("hold.ready_during_frame", 32'(rdy_n), 32'd0);
        check("hold.frame_end_timeout", 32'(busy), 32'd0);
        expect_frame(8'hE7, 0, "hold");
        req_valid = 2'b00;
        repeat (3) tick();
        check("hold.once_busy", 32'(busy), 32'd0);
        check("hold.once_txd", 32'(txd), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single system UART transmit line between NUM_REQ byte producers, e.g. the CPU UART peripheral and the debug/boot monitor.
- Round-robin arbitration picks one requester per frame; an optional lock lets a requester keep ownership for a multi-byte message.
- The block sequences 8N1 framing at a fixed bit period and drives the TXD pin of the system top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CLKS_PER_BIT, 1250, clock cycles per UART bit (9600 baud on the system clock).
- DATA_W, 8, payload bits per frame (fixed 8; any other value is illegal).

Ports:
- i_CLK  input  1  system clock, rising edge.
- i_RST_N  input  1  asynchronous, active-low reset.
- i_REQ_VALID  input  NUM_REQ  per-requester byte valid.
- i_REQ_DATA  input  NUM_REQ*8  packed bytes; requester k uses [8k+7:8k].
- i_REQ_LOCK  input  NUM_REQ  keep ownership after the current frame.
- o_REQ_READY  output  NUM_REQ  one-hot accept strobe.
- o_GRANT_ID  output  clog2(NUM_REQ) (min 1)  index of the current or last owner.
- o_BUSY  output  1  frame in progress.
- o_UART_TXD  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, sync release):
  - o_UART_TXD=1, o_REQ_READY=0, o_BUSY=0, o_GRANT_ID=0.
  - Round-robin pointer set so requester 0 has highest priority; lock owner cleared; state IDLE.
  - Reset mid-frame aborts the frame immediately; TXD goes high asynchronously.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If any i_REQ_VALID is high, a winner g is chosen.
  - Selection: if a lock owner exists and it is valid, g is the lock owner. Otherwise g is the first valid requester searching upward from pointer+1, modulo NUM_REQ.
  - In the same cycle: o_REQ_READY[g]=1 (registered-output equivalent not required; combinational from state/valid is allowed), byte latched into the shift register, o_GRANT_ID<=g, state->START.
  - Handshake completes when valid&ready are both high. A requester must hold valid and data stable until ready.
  - If the lock owner is not valid in IDLE, the lock is released and normal round-robin applies.
- START: TXD=0 for CLKS_PER_BIT cycles, then state->DATA.
- DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7; state->STOP after bit 7.
- STOP: TXD=1 for CLKS_PER_BIT cycles, then state->IDLE.
- Lock and pointer update at end of STOP: lock owner <= g if i_REQ_LOCK[g]=1, else none. The pointer advances to g only when the frame was not granted via lock.
- Baud counter: 0..CLKS_PER_BIT-1; restarts at 0 on entry to START; no drift between bits.
- Frame timing: TXD falls 1 cycle after the accept cycle; the frame lasts exactly 10*CLKS_PER_BIT cycles.
- The earliest next accept is the cycle after STOP ends, giving back-to-back frames with no idle bit.
- o_BUSY=1 in START/DATA/STOP, 0 in IDLE.
- o_REQ_READY is at most one-hot and is 0 outside IDLE.
- Valid changes during a frame are ignored until IDLE.

Decomposition:
- Shared package uart_pkg: FSM state encoding, constant UART_DATA_BITS=8, and default CLKS_PER_BIT_9600=1250, which the system top level also uses for the RX side.
- One natural sub-module, rr_arbiter: combinational round-robin priority select with pointer input, lock override, and one-hot plus index outputs.
- The UART FSM/shift register stays in uart_tx_scheduler.

Test Plan (CLKS_PER_BIT=4, NUM_REQ=2):
- Single byte: req0 sends 0x61 -> ready0 for 1 cycle. TXD = 0,1,0,0,0,0,1,1,0,1, each 4 cycles, 40 cycles total; busy high 40 cycles; grant_id=0.
- Contention: both valid at reset release, bytes 0xA5/0x3C -> 0xA5 first (req0), then 0x3C, back-to-back with no extra idle cycle. A third round with both still valid serves req0 again.
- Lock: req1 lock=1 with 3 bytes 0x10,0x11,0x12 while req0 valid -> all three req1 frames consecutive; req0 is served after req1 drops lock.
- Lock release by idle: req1 lock=1 but valid drops at frame end -> next grant goes to req0 per round-robin.
- Reset mid-frame: assert i_RST_N=0 at cycle 15 of a frame -> TXD=1, busy=0, ready=0 in the same cycle without a clock edge. After release, a new byte 0x55 is sent as a complete, correct frame.
- Hold stability: valid asserted during a frame for 20 cycles -> no ready pulse until IDLE; data then captured exactly once.
